cdu_read_counter: RTL and testbench
===================================

Name: cdu_read_counter

Overview:
- Digital tracking loop downstream of the main summing amplifier.
- Samples the fine-error Schmitt-trigger outputs _TLF2H and _TLF1H, plus an error-sign input. Steps a 16-bit angle counter up or down.
- Emits one +/- increment pulse per step toward the guidance computer.
- The counter's low 7 bits drive the active-low fine-ladder bits _D15.._D21 back into the summing amplifier, closing the loop.

Parameters:
- SETTLE_CYCLES, 4: clock cycles the ladder is held after each step before sampling resumes (1..255).
- LOW_DIV, 8: sample ticks per step when only _TLF1H is asserted (1..255).
- FAIL_SAMPLES, 64: consecutive _TLF2H samples that flag failure (1..1023; used only with CDU_FAIL_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle sampling strobe (nominal 12.8 kHz equivalent).
- _TLF2H  in  1  fine error above high threshold.
- _TLF1H  in  1  fine error above low threshold.
- err_neg  in  1  error sign: 1 = counter ahead of the resolver, step down; 0 = step up.
- zero_req  in  1  synchronous clear of the angle counter.
- angle  out  16  angle counter.
- _D15 .. _D21  out  1 each  active-low ladder bits; _D15 = ~angle[6] … _D21 = ~angle[0].
- pcdu  out  1  one-cycle pulse on an up-step.
- mcdu  out  1  one-cycle pulse on a down-step.
- busy  out  1  high in STEP or SETTLE.
- cdu_fail  out  1  sticky failure flag.

Behaviour:
- Reset (async, rst_n low):
  - angle=0, so all _D15.._D21=1.
  - pcdu=mcdu=0, busy=0, cdu_fail=0.
  - State IDLE; low-rate divider and fail counter cleared.
  - Reset mid-step abandons the step with no pulse.
- States:
  - IDLE: waits for sample_tick.
  - STEP: one cycle.
  - SETTLE: SETTLE_CYCLES cycles, then back to IDLE.
- Decision in IDLE on a cycle with sample_tick=1, using that cycle's inputs:
  - _TLF2H=1: go to STEP and clear the divider.
  - _TLF2H=0, _TLF1H=1: if divider==LOW_DIV-1, clear the divider and go to STEP; else increment the divider and stay in IDLE.
  - Both 0: clear the divider and stay in IDLE.
- STEP cycle (registered outputs, all valid on the edge that leaves STEP):
  - angle <= angle-1 if err_neg, else angle+1.
  - mcdu or pcdu =1 for exactly this cycle; the _D outputs update on the same edge.
  - Latency: sample_tick cycle → counter change and pulse visible 1 cycle later → SETTLE_CYCLES cycles → IDLE.
- sample_tick arriving during STEP or SETTLE is ignored and not queued.
- Arithmetic is modulo 2^16: 0xFFFF+1 → 0x0000, emits pcdu; 0x0000-1 → 0xFFFF, emits mcdu.
- zero_req:
  - In any state, next edge: angle=0, divider cleared, cdu_fail cleared, state IDLE, no pulse.
  - zero_req beats a simultaneous step.
- pcdu and mcdu are never high together. Each is high for at most 1 cycle per SETTLE_CYCLES+1 cycles.
- _TLF2H=1 with _TLF1H=0 is treated as a high error.

Optional Feature:
- Macro: CDU_FAIL_EN.
- With it defined:
  - A fail counter increments on every sample_tick seen in IDLE with _TLF2H=1.
  - It clears on a sample_tick seen in IDLE with _TLF2H=0.
  - When the counter reaches FAIL_SAMPLES, cdu_fail sets and stays set until reset or zero_req.
  - The counter saturates at FAIL_SAMPLES.
  - Stepping continues regardless of cdu_fail.
- Without it: no fail counter is built, cdu_fail is tied to 0, and FAIL_SAMPLES is unused.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high, with ticks and both TLF=0 for 100 ticks → angle=0x0000, _D15.._D21 all 1, no pcdu/mcdu.
- High-rate up: _TLF2H=1, err_neg=0, tick every 20 cycles, 10 ticks → angle=10, 10 pcdu pulses, each 1 cycle after its tick. Then assert err_neg=1 for 3 ticks → angle=7, 3 mcdu pulses.
- Low-rate down with wrap: angle=0, _TLF1H=1 only, err_neg=1, LOW_DIV=8, 16 ticks → exactly 2 mcdu pulses, on the 8th and 16th tick; angle=0xFFFE, ladder bits _D15.._D21 = ~0x7E (0,0,0,0,0,0,1).
- Settle hold-off: SETTLE_CYCLES=4, _TLF2H=1, ticks on consecutive cycles for 20 cycles → a step every 6 cycles (tick cycle, STEP, 4 SETTLE cycles), i.e. 4 steps; ticks during busy are dropped.
- zero_req collision and async reset: angle=0x1234, zero_req on the same cycle as a high-error tick → angle=0, no pulse. rst_n pulsed low during SETTLE → all outputs return to reset values immediately.
- CDU_FAIL_EN, FAIL_SAMPLES=64: 63 high-error ticks, one tick with _TLF2H=0, then 64 more → cdu_fail rises only on the 64th tick of the second run; zero_req clears it. Without the macro, cdu_fail stays 0 throughout.

Source files
------------

// File: rtl/cdu_read_counter.sv
// cdu_read_counter: fine-error tracking counter for the CDU read loop.
// Samples the fine-error Schmitt outputs on each sample tick, steps a 16-bit
// angle counter toward the resolver, emits one +/- pulse per step and drives
// the active-low fine ladder bits from the counter's low 7 bits.
// Optional build macro: CDU_FAIL_EN adds the sticky high-error failure flag.
module cdu_read_counter #(
  parameter int SETTLE_CYCLES = 4,
  parameter int LOW_DIV       = 8,
  parameter int FAIL_SAMPLES  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic        _TLF2H,
  input  logic        _TLF1H,
  input  logic        err_neg,
  input  logic        zero_req,
  output logic [15:0] angle,
  output logic        _D15,
  output logic        _D16,
  output logic        _D17,
  output logic        _D18,
  output logic        _D19,
  output logic        _D20,
  output logic        _D21,
  output logic        pcdu,
  output logic        mcdu,
  output logic        busy,
  output logic        cdu_fail
);

  typedef enum logic [1:0] {IDLE, STEP, SETTLE} state_t;

  state_t     state;
  logic [7:0] div;
  logic [7:0] settle_cnt;
  logic       div_hit;
  logic       step_req;

  // The low-rate divider only matters when _TLF2H is clear; a high error
  // (including the odd _TLF2H=1/_TLF1H=0 case) always steps immediately.
  assign div_hit  = (div == 8'(LOW_DIV - 1));
  assign step_req = sample_tick & (_TLF2H | (_TLF1H & div_hit));

  // Tracking FSM: decide on a tick in IDLE, step with a one-cycle pulse, then hold the ladder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      angle      <= 16'h0000;
      div        <= 8'h00;
      settle_cnt <= 8'h00;
      pcdu       <= 1'b0;
      mcdu       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pcdu <= 1'b0;
      mcdu <= 1'b0;
      if (zero_req) begin
        state      <= IDLE;
        angle      <= 16'h0000;
        div        <= 8'h00;
        settle_cnt <= 8'h00;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sample_tick) begin
              if (step_req) begin
                state <= STEP;
                busy  <= 1'b1;
                div   <= 8'h00;
                if (err_neg) begin
                  angle <= angle - 16'h0001;
                  mcdu  <= 1'b1;
                end else begin
                  angle <= angle + 16'h0001;
                  pcdu  <= 1'b1;
                end
              end else if (_TLF1H) begin
                div <= div + 8'h01;
              end else begin
                div <= 8'h00;
              end
            end
          end
          STEP: begin
            state      <= SETTLE;
            busy       <= 1'b1;
            settle_cnt <= 8'(SETTLE_CYCLES - 1);
          end
          SETTLE: begin
            if (settle_cnt == 8'h00) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              settle_cnt <= settle_cnt - 8'h01;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Ladder bits are the inverted low 7 counter bits, MSB first.
  always_comb begin
    _D15 = ~angle[6];
    _D16 = ~angle[5];
    _D17 = ~angle[4];
    _D18 = ~angle[3];
    _D19 = ~angle[2];
    _D20 = ~angle[1];
    _D21 = ~angle[0];
  end

`ifdef CDU_FAIL_EN
  logic [9:0] fail_cnt;

  // Count consecutive high-error samples taken in IDLE; flag is sticky until reset or zero_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= 10'd0;
      cdu_fail <= 1'b0;
    end else if (zero_req) begin
      fail_cnt <= 10'd0;
      cdu_fail <= 1'b0;
    end else if ((state == IDLE) && sample_tick) begin
      if (_TLF2H) begin
        if (fail_cnt != 10'(FAIL_SAMPLES)) begin
          fail_cnt <= fail_cnt + 10'd1;
        end
        if (fail_cnt == 10'(FAIL_SAMPLES - 1)) begin
          cdu_fail <= 1'b1;
        end
      end else begin
        fail_cnt <= 10'd0;
      end
    end
  end
`else
  logic [9:0] unused_fail_samples;

  assign unused_fail_samples = 10'(FAIL_SAMPLES);
  assign cdu_fail            = 1'b0;
`endif

endmodule

// File: tb/tb_cdu_read_counter.sv
// tb_cdu_read_counter: directed self-checking bench for cdu_read_counter.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_cdu_read_counter;

  logic        clk;
  logic        rst_n;
  logic        sample_tick;
  logic        _TLF2H;
  logic        _TLF1H;
  logic        err_neg;
  logic        zero_req;
  logic [15:0] angle;
  logic        _D15, _D16, _D17, _D18, _D19, _D20, _D21;
  logic        pcdu;
  logic        mcdu;
  logic        busy;
  logic        cdu_fail;
  logic [6:0]  ladder;

  int checks   = 0;
  int failures = 0;
  int pcnt     = 0;
  int mcnt     = 0;
  int both_cnt = 0;
  int p0;
  int m0;

  cdu_read_counter #(
    .SETTLE_CYCLES(4),
    .LOW_DIV(8),
    .FAIL_SAMPLES(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_tick(sample_tick),
    ._TLF2H(_TLF2H),
    ._TLF1H(_TLF1H),
    .err_neg(err_neg),
    .zero_req(zero_req),
    .angle(angle),
    ._D15(_D15),
    ._D16(_D16),
    ._D17(_D17),
    ._D18(_D18),
    ._D19(_D19),
    ._D20(_D20),
    ._D21(_D21),
    .pcdu(pcdu),
    .mcdu(mcdu),
    .busy(busy),
    .cdu_fail(cdu_fail)
  );

  assign ladder = {_D15, _D16, _D17, _D18, _D19, _D20, _D21};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pcdu) pcnt++;
    if (mcdu) mcnt++;
    if (pcdu && mcdu) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle tick; returns at the falling edge of the cycle after the tick.
  task automatic do_tick(input logic t2, input logic t1, input logic neg);
    @(negedge clk);
    sample_tick = 1'b1;
    _TLF2H      = t2;
    _TLF1H      = t1;
    err_neg     = neg;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic do_zero();
    @(negedge clk);
    zero_req = 1'b1;
    @(negedge clk);
    zero_req = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    _TLF2H      = 1'b0;
    _TLF1H      = 1'b0;
    err_neg     = 1'b0;
    zero_req    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_angle", 32'(angle), 32'h0);
    chk("rst_ladder", 32'(ladder), 32'h7f);
    chk("rst_pcdu", 32'(pcdu), 32'h0);
    chk("rst_mcdu", 32'(mcdu), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fail", 32'(cdu_fail), 32'h0);
    rst_n = 1'b1;

    // Idle ticks with no error
    p0 = pcnt;
    m0 = mcnt;
    for (int i = 0; i < 100; i++) do_tick(1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("idle_angle", 32'(angle), 32'h0);
    chk("idle_ladder", 32'(ladder), 32'h7f);
    chk("idle_pcnt", pcnt - p0, 0);
    chk("idle_mcnt", mcnt - m0, 0);

    // High-rate up then down
    p0 = pcnt;
    for (int i = 0; i < 10; i++) begin
      do_tick(1'b1, 1'b0, 1'b0);
      chk("hi_up_pulse", 32'(pcdu), 32'h1);
      chk("hi_up_nomcdu", 32'(mcdu), 32'h0);
      @(negedge clk);
      chk("hi_up_onecycle", 32'(pcdu), 32'h0);
      chk("hi_up_busy", 32'(busy), 32'h1);
      repeat (17) @(negedge clk);
    end
    chk("hi_up_angle", 32'(angle), 32'd10);
    chk("hi_up_count", pcnt - p0, 10);
    m0 = mcnt;
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b1, 1'b0, 1'b1);
      chk("hi_dn_pulse", 32'(mcdu), 32'h1);
      repeat (18) @(negedge clk);
    end
    chk("hi_dn_angle", 32'(angle), 32'd7);
    chk("hi_dn_count", mcnt - m0, 3);

    // Low-rate down with wrap through zero
    do_zero();
    chk("zero_angle", 32'(angle), 32'h0);
    m0 = mcnt;
    for (int i = 0; i < 16; i++) begin
      do_tick(1'b0, 1'b1, 1'b1);
      chk("lo_dn_pulse", 32'(mcdu), 32'((i == 7) || (i == 15)));
      repeat (18) @(negedge clk);
    end
    chk("lo_dn_angle", 32'(angle), 32'hfffe);
    chk("lo_dn_ladder", 32'(ladder), 32'h01);
    chk("lo_dn_count", mcnt - m0, 2);

    // Settle hold-off with tick held high for 20 cycles
    do_zero();
    p0 = pcnt;
    sample_tick = 1'b1;
    _TLF2H      = 1'b1;
    _TLF1H      = 1'b0;
    err_neg     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("settle_pulse", 32'(pcdu), 32'((c % 6) == 0));
    end
    sample_tick = 1'b0;
    repeat (8) @(negedge clk);
    chk("settle_count", pcnt - p0, 4);
    chk("settle_angle", 32'(angle), 32'd4);

    // Climb to 0x1234 for the collision test
    do_zero();
    p0 = pcnt;
    sample_tick = 1'b1;
    _TLF2H      = 1'b1;
    for (int c = 0; c < 40000 && (pcnt - p0) < 32'h1234; c++) @(negedge clk);
    sample_tick = 1'b0;
    chk("climb_count", pcnt - p0, 32'h1234);
    repeat (8) @(negedge clk);
    chk("climb_angle", 32'(angle), 32'h1234);

    // zero_req beats a simultaneous high-error tick
    p0 = pcnt;
    m0 = mcnt;
    @(negedge clk);
    zero_req    = 1'b1;
    sample_tick = 1'b1;
    _TLF2H      = 1'b1;
    @(negedge clk);
    zero_req    = 1'b0;
    sample_tick = 1'b0;
    chk("coll_angle", 32'(angle), 32'h0);
    chk("coll_pcdu", 32'(pcdu), 32'h0);
    chk("coll_busy", 32'(busy), 32'h0);
    repeat (8) @(negedge clk);
    chk("coll_pcnt", pcnt - p0, 0);
    chk("coll_mcnt", mcnt - m0, 0);
    chk("coll_angle_hold", 32'(angle), 32'h0);

    // Async reset during SETTLE
    do_tick(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    chk("pre_rst_angle", 32'(angle), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_angle", 32'(angle), 32'h0);
    chk("async_ladder", 32'(ladder), 32'h7f);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_pcdu", 32'(pcdu), 32'h0);
    chk("async_mcdu", 32'(mcdu), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef CDU_FAIL_EN
    // Failure flag: 63 highs, a break, then 64 highs
    for (int i = 0; i < 63; i++) begin
      do_tick(1'b1, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
    end
    chk("fail_63", 32'(cdu_fail), 32'h0);
    do_tick(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("fail_break", 32'(cdu_fail), 32'h0);
    for (int i = 0; i < 64; i++) begin
      do_tick(1'b1, 1'b0, 1'b0);
      chk("fail_run2", 32'(cdu_fail), 32'(i == 63));
      repeat (6) @(negedge clk);
    end
    do_tick(1'b1, 1'b0, 1'b0);
    chk("fail_sticky", 32'(cdu_fail), 32'h1);
    chk("fail_still_steps", 32'(pcdu), 32'h1);
    repeat (6) @(negedge clk);
    do_zero();
    chk("fail_zero_clear", 32'(cdu_fail), 32'h0);
`else
    for (int i = 0; i < 70; i++) begin
      do_tick(1'b1, 1'b0, 1'b0);
      chk("nofail_flag", 32'(cdu_fail), 32'h0);
      repeat (6) @(negedge clk);
    end
`endif

    chk("never_both", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
